nth_root_seq: RTL

// - Parametrised fixed-point n-th root engine; successor to the Q10.10 root unit.
// - Finds floor-truncated y = x^(1/n) bit by bit, MSB first, in unsigned Q(INT_W).(FRAC_W).
// - Sits behind the operand-issue stage; results go to the writeback mux over a valid/ready pair.
// - Added over the earlier unit: generic widths, output backpressure, overflow-safe power, error and exact flags.

---
 rtl/nth_root_seq_pkg.sv | 21 ++
 rtl/nth_root_seq_if.sv | 29 ++
 rtl/nth_root_seq_pow_unit.sv | 44 ++++
 rtl/nth_root_seq.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/nth_root_seq_pkg.sv
// Shared types and width helpers for the fixed-point n-th root engine.
// State encoding and default Q-format widths.
package nth_root_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    POW,
    CMP,
    DONE
  } state_t;

  localparam int DEF_INT_W  = 10;
  localparam int DEF_FRAC_W = 10;
  localparam int DEF_EXP_W  = 3;

  function automatic int calc_w(input int int_w, input int frac_w);
    return int_w + frac_w;
  endfunction

endpackage

// File: rtl/nth_root_seq_if.sv
// Operand/result handshake bundle for the n-th root engine.
// Master issues operands and consumes results; slave is the engine.
interface nth_root_seq_if #(
  parameter int INT_W  = 10,
  parameter int FRAC_W = 10,
  parameter int EXP_W  = 3
);
  localparam int W = INT_W + FRAC_W;

  logic              in_valid;
  logic              in_ready;
  logic [INT_W-1:0]  in_data_1;
  logic [EXP_W-1:0]  in_data_2;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_exact;
  logic              out_err;

  modport master (
    output in_valid, in_data_1, in_data_2, out_ready,
    input  in_ready, out_valid, out_data, out_exact, out_err
  );

  modport slave (
    input  in_valid, in_data_1, in_data_2, out_ready,
    output in_ready, out_valid, out_data, out_exact, out_err
  );
endinterface

// File: rtl/nth_root_seq_pow_unit.sv
// Iterated truncating power: p = cand^n in Q format, one multiply per cycle.
// done is raised during the final multiply so the caller can move on next edge.
module nth_root_pow_unit #(
  parameter int W      = 20,
  parameter int FRAC_W = 10,
  parameter int EXP_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     cand,
  input  logic [EXP_W-1:0] n,
  output logic [W-1:0]     p,
  output logic             ovf,
  output logic             done
);
  logic [W-1:0]     c_q;
  logic [EXP_W-1:0] cnt;
  logic [2*W-1:0]   prod;
  logic [2*W-1:0]   sh;

  assign prod = {{W{1'b0}}, p} * {{W{1'b0}}, c_q};
  assign sh   = prod >> FRAC_W;
  assign done = cnt == EXP_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p   <= '0;
      c_q <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (start) begin
      p   <= cand;
      c_q <= cand;
      cnt <= n - EXP_W'(1);
      ovf <= 1'b0;
    end else if (cnt != '0) begin
      // anything spilling past W bits makes the candidate too large
      p   <= sh[W-1:0];
      ovf <= ovf | (|sh[2*W-1:W]);
      cnt <= cnt - EXP_W'(1);
    end
  end
endmodule

// File: rtl/nth_root_seq.sv
// Bit-serial fixed-point n-th root, MSB first, floor-truncated result.
// Owns the sequencing FSM, trial-bit registers and result handshake.
module nth_root_seq
  import nth_root_pkg::*;
#(
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int EXP_W  = DEF_EXP_W
) (
  input logic            clk,
  input logic            rst_n,
  nth_root_seq_if.slave  io
);
  localparam int W = calc_w(INT_W, FRAC_W);
  localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

  state_t           st, st_nx;
  logic [INT_W-1:0] x_q;
  logic [EXP_W-1:0] n_q;
  logic [W-1:0]     bit_q, bit_nx;
  logic [W-1:0]     res_q, res_nx;
  logic [W-1:0]     tgt_q, tgt_nx;
  logic [W-1:0]     cand, pow_cand, p;
  logic             exact_q, exact_nx;
  logic             err_q, err_nx;
  logic             start, ovf, pow_done, keep, accept;

  assign accept = io.in_valid && io.in_ready;
  assign cand   = res_q | bit_q;
  assign keep   = !ovf && (p <= tgt_q);

  nth_root_pow_unit #(
    .W      (W),
    .FRAC_W (FRAC_W),
    .EXP_W  (EXP_W)
  ) u_pow (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .cand  (pow_cand),
    .n     (n_q),
    .p     (p),
    .ovf   (ovf),
    .done  (pow_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= IDLE;
      x_q     <= '0;
      n_q     <= '0;
      bit_q   <= '0;
      res_q   <= '0;
      tgt_q   <= '0;
      exact_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st      <= st_nx;
      bit_q   <= bit_nx;
      res_q   <= res_nx;
      tgt_q   <= tgt_nx;
      exact_q <= exact_nx;
      err_q   <= err_nx;
      if (accept) begin
        x_q <= io.in_data_1;
        n_q <= io.in_data_2;
      end
    end
  end

  always_comb begin
    st_nx    = st;
    bit_nx   = bit_q;
    res_nx   = res_q;
    tgt_nx   = tgt_q;
    exact_nx = exact_q;
    err_nx   = err_q;
    start    = 1'b0;
    unique case (st)
      IDLE: begin
        if (accept) begin
          st_nx    = LOAD;
          exact_nx = 1'b0;
          err_nx   = 1'b0;
        end
      end
      LOAD: begin
        bit_nx = MSB;
        res_nx = '0;
        tgt_nx = W'(x_q) << FRAC_W;
        unique case (1'b1)
          (n_q == '0): begin
            res_nx = '1;
            err_nx = 1'b1;
            st_nx  = DONE;
          end
          (n_q == EXP_W'(1)): begin
            res_nx   = tgt_nx;
            exact_nx = 1'b1;
            st_nx    = DONE;
          end
          (x_q == '0): begin
            exact_nx = 1'b1;
            st_nx    = DONE;
          end
          default: begin
            start = 1'b1;
            st_nx = POW;
          end
        endcase
      end
      POW: begin
        if (pow_done) st_nx = CMP;
      end
      CMP: begin
        if (keep) res_nx = cand;
        if (keep && p == tgt_q) begin
          exact_nx = 1'b1;
          st_nx    = DONE;
        end else begin
          bit_nx = bit_q >> 1;
          if (bit_nx == '0) begin
            st_nx = DONE;
          end else begin
            start = 1'b1;
            st_nx = POW;
          end
        end
      end
      DONE: begin
        if (io.out_ready) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
    // next trial value is seeded from the updated registers
    pow_cand = res_nx | bit_nx;
  end

  assign io.in_ready  = st == IDLE;
  assign io.out_valid = st == DONE;
  assign io.out_data  = io.out_valid ? res_q : '0;
  assign io.out_exact = io.out_valid && exact_q;
  assign io.out_err   = io.out_valid && err_q;
endmodule
